// File: rtl/simon_playback.sv
// Simon sequence playback: walks the sequence ROM from step 0 to len-1, lighting one LED per
// step for ON_TICKS slow ticks followed by an OFF_TICKS blank gap, then pulses done.
module simon_playback #(
    parameter int DEPTH     = 16,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len, len_nxt;
    logic [ADDR_W-1:0] step_nxt;
    logic [3:0]        led_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last_step;

    assign last_step = ({1'b0, step} == (len - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            len   <= '0;
            step  <= '0;
            led   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            step  <= step_nxt;
            led   <= led_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        step_nxt  = step;
        led_nxt   = led;
        cnt_nxt   = cnt;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_nxt   = (length > DEPTH_L) ? DEPTH_L : length;
                    step_nxt  = '0;
                    state_nxt = (length == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_LOAD;
            // rd_data now reflects the address presented during FETCH
            ST_LOAD: begin
                led_nxt   = 4'b0001 << rd_data;
                cnt_nxt   = '0;
                state_nxt = ST_ON;
            end
            ST_ON: begin
                if (tick) begin
                    if (cnt == ON_LAST) begin
                        cnt_nxt   = '0;
                        led_nxt   = '0;
                        state_nxt = ST_OFF;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (cnt == OFF_LAST) begin
                        cnt_nxt = '0;
                        if (last_step) begin
                            state_nxt = ST_DONE;
                        end else begin
                            step_nxt  = step + 1'b1;
                            state_nxt = ST_FETCH;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // abort overrides every transition above, including a pending DONE
        if (abort) begin
            state_nxt = ST_IDLE;
            led_nxt   = '0;
            step_nxt  = '0;
            cnt_nxt   = '0;
        end
    end

    assign rd_addr = step;
    assign busy    = (state == ST_FETCH) || (state == ST_LOAD) ||
                     (state == ST_ON)    || (state == ST_OFF);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_simon_playback.sv
// Self-checking bench for simon_playback: a procedural playback model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_simon_playback;

    localparam int DEPTH     = 16;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 1;
    localparam int ADDR_W    = 4;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              tick   = 1'b0;
    logic              start  = 1'b0;
    logic              abort  = 1'b0;
    logic [ADDR_W:0]   length = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_data;
    logic [3:0]        led;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] step;

    logic [1:0] rom [DEPTH];

    int total = 0;
    int bad   = 0;
    bit chk_en    = 1'b0;
    bit slow_tick = 1'b0;
    int tick_phase = 0;

    logic [3:0]        exp_led  = '0;
    logic              exp_busy = 1'b0;
    logic              exp_done = 1'b0;
    logic [ADDR_W-1:0] exp_step = '0;

    simon_playback #(
        .DEPTH    (DEPTH),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .start  (start),
        .abort  (abort),
        .length (length),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .led    (led),
        .busy   (busy),
        .done   (done),
        .step   (step)
    );

    always #5 clk = ~clk;

    // registered ROM: data follows the address by one cycle
    always_ff @(posedge clk) rd_data <= rom[rd_addr];

    initial begin
        forever begin
            @(negedge clk);
            tick_phase = (tick_phase + 1) % 4;
            tick = slow_tick ? (tick_phase == 0) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_edge(output bit killed, output bit tk);
        @(posedge clk);
        tk     = tick;
        killed = reset || abort;
        if (killed) begin
            exp_led  = '0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_step = '0;
        end
    endtask

    task automatic model_play(input int n);
        bit killed;
        bit tk;
        int ticks;
        for (int k = 0; k < n; k++) begin
            exp_step = ADDR_W'(k);
            exp_busy = 1'b1;
            exp_led  = '0;
            exp_done = 1'b0;
            model_edge(killed, tk);
            if (killed) return;
            model_edge(killed, tk);
            if (killed) return;
            exp_led = 4'b0001 << rom[k];
            ticks = 0;
            while (ticks < ON_TICKS) begin
                model_edge(killed, tk);
                if (killed) return;
                if (tk) ticks++;
            end
            exp_led = '0;
            ticks = 0;
            while (ticks < OFF_TICKS) begin
                model_edge(killed, tk);
                if (killed) return;
                if (tk) ticks++;
            end
        end
        exp_busy = 1'b0;
        exp_done = 1'b1;
        model_edge(killed, tk);
        exp_done = 1'b0;
    endtask

    initial begin : model
        bit killed;
        bit tk;
        int n;
        forever begin
            model_edge(killed, tk);
            if (!killed && start) begin
                n = (int'(length) > DEPTH) ? DEPTH : int'(length);
                exp_step = '0;
                if (n == 0) begin
                    exp_done = 1'b1;
                    model_edge(killed, tk);
                    exp_done = 1'b0;
                end else begin
                    model_play(n);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checkOutput("model_led",     8'(led),     8'(exp_led));
                checkOutput("model_busy",    8'(busy),    8'(exp_busy));
                checkOutput("model_done",    8'(done),    8'(exp_done));
                checkOutput("model_step",    8'(step),    8'(exp_step));
                checkOutput("model_rd_addr", 8'(rd_addr), 8'(exp_step));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic applyStimulus(input logic s, input logic a, input logic r, input int len_v);
        @(negedge clk);
        start  = s;
        abort  = a;
        reset  = r;
        length = (ADDR_W + 1)'(len_v);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves the caller at the negedge of cycle t+1, t being the acceptance cycle
    task automatic start_play(input int len_v);
        applyStimulus(1'b1, 1'b0, 1'b0, len_v);
        applyStimulus(1'b0, 1'b0, 1'b0, len_v);
    endtask

    initial begin
        logic [1:0] init_rom [DEPTH];
        bit seen;
        init_rom = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3,
                     2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0};
        for (int i = 0; i < DEPTH; i++) rom[i] = init_rom[i];

        wait_neg(2);
        reset  = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_led",  8'(led),  8'h0);
        checkOutput("reset_busy", 8'(busy), 8'h0);
        checkOutput("reset_step", 8'(step), 8'h0);
        wait_neg(2);

        // four steps, tick held high
        start_play(4);
        checkOutput("t1_busy_fetch", 8'(busy), 8'h1);
        checkOutput("t1_rd_addr0",   8'(rd_addr), 8'h0);
        wait_neg(2);
        checkOutput("t1_led_step0", 8'(led), 8'h1);
        wait_neg(2);
        checkOutput("t1_led_gap0",  8'(led), 8'h0);
        wait_neg(3);
        checkOutput("t1_led_step1", 8'(led), 8'h8);
        wait_neg(5);
        checkOutput("t1_led_step2", 8'(led), 8'h2);
        wait_neg(5);
        checkOutput("t1_led_step3", 8'(led), 8'h4);
        wait_neg(3);
        checkOutput("t1_done",      8'(done), 8'h1);
        checkOutput("t1_busy_done", 8'(busy), 8'h0);
        wait_neg(1);
        checkOutput("t1_done_pulse", 8'(done), 8'h0);
        wait_neg(2);

        // slow pacing, single step showing LED 2
        rom[0]    = 2'd2;
        slow_tick = 1'b1;
        start_play(1);
        wait_neg(2);
        checkOutput("t2_led_on", 8'(led), 8'h4);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            wait_neg(1);
            if (done) seen = 1'b1;
        end
        checkOutput("t2_done_seen", 8'(seen), 8'h1);
        slow_tick = 1'b0;
        rom[0]    = init_rom[0];
        wait_neg(2);

        // zero-length request
        start_play(0);
        checkOutput("t3_done", 8'(done), 8'h1);
        checkOutput("t3_busy", 8'(busy), 8'h0);
        checkOutput("t3_led",  8'(led),  8'h0);
        wait_neg(1);
        checkOutput("t3_done_pulse", 8'(done), 8'h0);
        wait_neg(2);

        // over-long request clamps to DEPTH steps
        start_play(20);
        wait_neg(75);
        checkOutput("t4_last_step",    8'(step),    8'd15);
        checkOutput("t4_last_rd_addr", 8'(rd_addr), 8'd15);
        wait_neg(5);
        checkOutput("t4_done", 8'(done), 8'h1);
        wait_neg(2);

        // abort in the second ON cycle of step 1, then immediate restart
        start_play(4);
        wait_neg(7);
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        checkOutput("t5_led_before_abort", 8'(led), 8'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("t5_led_abort",  8'(led),  8'h0);
        checkOutput("t5_busy_abort", 8'(busy), 8'h0);
        checkOutput("t5_done_abort", 8'(done), 8'h0);
        checkOutput("t5_step_abort", 8'(step), 8'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("t5_restart_busy", 8'(busy), 8'h1);
        wait_neg(20);
        checkOutput("t5_restart_done", 8'(done), 8'h1);
        wait_neg(2);

        // start pulses during playback and on the DONE cycle are ignored
        start_play(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        wait_neg(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        wait_neg(12);
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        checkOutput("t6_done", 8'(done), 8'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("t6_idle_busy", 8'(busy), 8'h0);
        checkOutput("t6_idle_done", 8'(done), 8'h0);
        checkOutput("t6_idle_step", 8'(step), 8'd3);
        wait_neg(2);

        // synchronous reset during step 2's OFF gap
        start_play(4);
        wait_neg(13);
        applyStimulus(1'b0, 1'b0, 1'b1, 4);
        checkOutput("t7_off_busy", 8'(busy), 8'h1);
        checkOutput("t7_off_step", 8'(step), 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("t7_reset_led",     8'(led),     8'h0);
        checkOutput("t7_reset_busy",    8'(busy),    8'h0);
        checkOutput("t7_reset_done",    8'(done),    8'h0);
        checkOutput("t7_reset_step",    8'(step),    8'h0);
        checkOutput("t7_reset_rd_addr", 8'(rd_addr), 8'h0);
        wait_neg(1);
        start_play(2);
        wait_neg(10);
        checkOutput("t7_after_reset_done", 8'(done), 8'h1);
        wait_neg(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_playback.md
# simon_playback

Plays the stored Simon sequence back to the player on the four LEDs, as the output-side counterpart to the button input path. On a start request it reads steps 0 to length-1 from the sequence ROM. Each step lights one LED for a programmable number of slow ticks, then blanks all LEDs for a gap. When the last step finishes it signals done. It sits between the sequence ROM (it drives the read port) and the game FSM (start/done handshake), and it shares the LED bus through the top-level mux.

## Interface
- DEPTH, 16, number of ROM entries; ADDR_W = clog2(DEPTH)
- ON_TICKS, 2, tick pulses each step's LED stays lit (≥1)
- OFF_TICKS, 1, tick pulses of blank gap after each step (≥1)

- clk  in  1  system clock (100 MHz); all logic on posedge clk
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle enable pulse from the slow divider; paces ON/OFF
- start  in  1  request playback; sampled only in IDLE
- abort  in  1  synchronous cancel; any state → IDLE
- length  in  ADDR_W+1  steps to play; 0 allowed; values > DEPTH clamp to DEPTH
- rd_addr  out  ADDR_W  ROM read address
- rd_data  in  2  ROM data; registered ROM, valid the cycle after rd_addr is presented
- led  out  4  one-hot step display (0→0001, 1→0010, 2→0100, 3→1000)
- busy  out  1  high in FETCH, LOAD, ON and OFF
- done  out  1  one-cycle pulse when playback completes
- step  out  ADDR_W  index of the step currently playing

## Operation
- States: IDLE, FETCH, LOAD, ON, OFF, DONE.
- IDLE
  - start=1 and abort=0: latch len = min(length, DEPTH) and set step=0.
  - If len=0, go to DONE. Otherwise go to FETCH.
- FETCH (1 cycle): rd_addr=step; go to LOAD.
- LOAD (1 cycle): register led ← onehot(rd_data), clear tick counter, go to ON.
- ON
  - Counter increments on each cycle with tick=1.
  - The cycle where tick=1 and count=ON_TICKS-1: next cycle led=0000, counter clears, state goes to OFF.
- OFF
  - Same counting, against OFF_TICKS.
  - On the final tick: if step=len-1, go to DONE; else step+1 and go to FETCH.
- DONE (1 cycle): done=1; go to IDLE.
- abort=1 in any state: next cycle state=IDLE, led=0000, busy=0, done=0, step=0.
  - abort has priority over start and over the DONE transition, so there is no done pulse after an abort.
- start while not in IDLE is ignored; length is read only at acceptance.
- Ticks outside ON/OFF are ignored. Counters are ADDR_W-independent, sized clog2(max(ON_TICKS,OFF_TICKS))+1.
- rd_addr holds step at all times. ROM reads in other states are harmless.

## Timing
- Reset values: state=IDLE, led=0000, busy=0, done=0, step=0, rd_addr=0, counters=0.
- Start accepted in cycle t (IDLE) → FETCH at t+1 with busy=1 and rd_addr=0; LOAD at t+2; led valid from t+3.
- With tick held high, one step lasts P = 2+ON_TICKS+OFF_TICKS cycles.
  - Step k enters FETCH at t+1+k·P.
  - done=1 exactly at cycle t+1+len·P; busy=0 in that cycle.
- len=0: done=1 at t+1, busy never asserts, led stays 0000.
- led is never non-zero outside ON; led changes only at state transitions.
- Back-to-back playback: earliest start acceptance is the cycle after DONE (IDLE).
- reset mid-playback acts like abort and additionally clears the latched len.

## Test plan
- ROM={0,3,1,2}, length=4, ON=2, OFF=1, tick=1 constant, start pulse at t:
  - led = 0001, 1000, 0010, 0100, each for 2 cycles, starting at t+3, t+8, t+13, t+18, with a 1-cycle 0000 gap after each.
  - done pulse at t+21.
- Slow pacing, tick every 4th cycle, length=1, ROM[0]=2: led=0100 until the 2nd tick seen in ON, then 0000 until the next tick, then done on the following cycle.
- length=0 start: done=1 at t+1, busy=0 throughout, led=0000.
- length=20 with DEPTH=16: exactly 16 steps play; step wraps never; last rd_addr=15.
- abort asserted in the 2nd cycle of step 1's ON phase: next cycle led=0000, busy=0, state IDLE; no done pulse; a new start is accepted the following cycle.
- start pulsed repeatedly during playback and at the DONE cycle: ignored, step sequence unchanged. Synchronous reset mid-OFF: all outputs return to reset values on the next cycle.
